// File: rtl/button_reader_pkg.sv
// Shared constants and helpers for the button_reader input peripheral.
// Register offsets match the peripheral bus map used by the display driver.
package button_reader_pkg;

   localparam logic REG_STATE  = 1'b0;
   localparam logic REG_EVENTS = 1'b1;

   // True when a word address falls inside the two-word window at base.
   function automatic logic in_window(input logic [31:0] a, input logic [31:0] base);
      return (a & ~32'd1) == base;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced input: 2-flop synchronizer, tick-driven history, held state.
// The next-state value is exported so the parent can update edge flags on the same clock.
module debounce_bit #(
   parameter int DEBOUNCE_SAMPLES = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tick,
   input  logic i_pin,
   output logic o_state,
   output logic o_state_nxt
);

   logic [1:0]                  r_sync;
   logic [DEBOUNCE_SAMPLES-1:0] r_hist;
   logic                        r_state;
   logic [DEBOUNCE_SAMPLES-1:0] w_hist_nxt;
   logic                        w_state_nxt;
   logic                        w_unused_oldest;

   // The oldest sample is shifted out before it is ever examined.
   assign w_unused_oldest = r_hist[DEBOUNCE_SAMPLES-1];

   // History shift and unanimous-vote state decision.
   always_comb begin
      w_hist_nxt  = r_hist;
      w_state_nxt = r_state;
      if (i_tick) begin
         w_hist_nxt = {r_hist[DEBOUNCE_SAMPLES-2:0], r_sync[1]};
         if (&w_hist_nxt) begin
            w_state_nxt = 1'b1;
         end else if (~|w_hist_nxt) begin
            w_state_nxt = 1'b0;
         end else begin
            w_state_nxt = r_state;
         end
      end else begin
         w_hist_nxt  = r_hist;
         w_state_nxt = r_state;
      end
   end

   // Synchronizer, history and state registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync  <= 2'b00;
         r_hist  <= '0;
         r_state <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_pin};
         r_hist  <= w_hist_nxt;
         r_state <= w_state_nxt;
      end
   end

   assign o_state     = r_state;
   assign o_state_nxt = w_state_nxt;

endmodule

// File: rtl/button_reader.sv
// Memory-mapped debounced button/switch reader with STATE and sticky EVENTS registers.
// Reads and writes are acknowledged one cycle after the strobe edge.
module button_reader
   import button_reader_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE        = 32'd1 << 5,
   parameter int          NUM_INPUTS       = 8,
   parameter int          COUNTER_BITS     = 16,
   parameter int          DEBOUNCE_SAMPLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  strobe,
   input  logic                  rw,
   input  logic [31:0]           addr,
   input  logic [31:0]           data,
   input  logic [NUM_INPUTS-1:0] pins,
   output logic [31:0]           q,
   output logic                  ack
);

   logic [COUNTER_BITS-1:0] r_prescale;
   logic [NUM_INPUTS-1:0]   r_events;
   logic                    w_tick;
   logic                    w_hit;
   logic                    w_sel;
   logic [NUM_INPUTS-1:0]   w_state;
   logic [NUM_INPUTS-1:0]   w_state_nxt;
   logic [NUM_INPUTS-1:0]   w_clr;
   logic [NUM_INPUTS-1:0]   w_events_nxt;
   logic [31:0]             w_rd_data;
   logic                    w_unused_data;

   assign w_tick        = &r_prescale;
   assign w_hit         = strobe && in_window(addr, ADDR_BASE);
   assign w_sel         = addr[0];
   assign w_unused_data = ^data;

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_db
      debounce_bit #(
         .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
      ) u_db (
         .i_clk      (clk),
         .i_rst      (reset),
         .i_tick     (w_tick),
         .i_pin      (pins[g]),
         .o_state    (w_state[g]),
         .o_state_nxt(w_state_nxt[g])
      );
   end

   // Read mux and EVENTS update; a rising edge wins over a clear on the same cycle.
   always_comb begin
      w_rd_data = 32'd0;
      w_clr     = '0;
      case (w_sel)
         REG_STATE:  w_rd_data[NUM_INPUTS-1:0] = w_state;
         REG_EVENTS: w_rd_data[NUM_INPUTS-1:0] = r_events;
         default:    w_rd_data = 32'd0;
      endcase
      if (w_hit && (w_sel == REG_EVENTS)) begin
         if (rw) begin
            w_clr = data[NUM_INPUTS-1:0];
         end else begin
            w_clr = r_events;
         end
      end else begin
         w_clr = '0;
      end
      w_events_nxt = (r_events & ~w_clr) | (w_state_nxt & ~w_state);
   end

   // Free-running sample prescaler.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prescale <= '0;
      end else begin
         r_prescale <= r_prescale + 1'b1;
      end
   end

   // EVENTS register and registered bus response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_events <= '0;
         q        <= 32'd0;
         ack      <= 1'b0;
      end else begin
         r_events <= w_events_nxt;
         ack      <= w_hit;
         if (w_hit && !rw) begin
            q <= w_rd_data;
         end else begin
            q <= q;
         end
      end
   end

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader: stimulus pushes expected read data into a queue,
// and a negedge monitor pops and compares on every ack.
module tb_button_reader;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic        strobe = 1'b0;
   logic        rw     = 1'b0;
   logic [31:0] addr   = 32'd0;
   logic [31:0] data   = 32'd0;
   logic [7:0]  pins   = 8'd0;
   logic [31:0] q;
   logic        ack;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_q = 32'd0;
   int          edge_cnt = 0;
   int          ack_streak = 0;
   int          max_streak = 0;

   button_reader #(
      .ADDR_BASE       (32'h20),
      .NUM_INPUTS      (8),
      .COUNTER_BITS    (2),
      .DEBOUNCE_SAMPLES(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .strobe(strobe),
      .rw    (rw),
      .addr  (addr),
      .data  (data),
      .pins  (pins),
      .q     (q),
      .ack   (ack)
   );

   always #5 clk = ~clk;

   // Edges since reset release; tick edges are the multiples of 4.
   always @(posedge clk or posedge reset) begin
      if (reset) edge_cnt <= 0;
      else       edge_cnt <= edge_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [31:0] e;
      if (reset) begin
         ack_streak = 0;
      end else if (ack) begin
         ack_streak++;
         if (ack_streak > max_streak) max_streak = ack_streak;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ack: got ack=1 q=%h expected no ack at %0t", q, $time);
         end else begin
            e = exp_q.pop_front();
            chk("ack_q", q, e);
         end
      end else begin
         ack_streak = 0;
      end
   end

   task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
      @(negedge clk);
      strobe = 1'b1; rw = w; addr = a; data = d;
      if (!w) last_q = e;
      exp_q.push_back(last_q);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         strobe = 1'b0;
      end
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e);
      acc(1'b0, a, 32'd0, e);
      idle(1);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      acc(1'b1, a, d, 32'd0);
      idle(1);
   endtask

   task automatic miss(input logic w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      strobe = 1'b1; rw = w; addr = a; data = d;
      @(negedge clk);
      strobe = 1'b0;
      chk("decode_ack", {31'd0, ack}, 32'd0);
      chk("decode_q", q, last_q);
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL ack_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int ep, t1, r;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Post-reset reads
      rd(32'h20, 32'h0);
      rd(32'h21, 32'h0);
      drain();

      // Debounce of a stable pattern, then a one-tick glitch on bit 7
      pins = 8'h05; idle(30);
      rd(32'h20, 32'h05);
      pins = 8'h85; idle(4);
      pins = 8'h05; idle(30);
      rd(32'h20, 32'h05);
      rd(32'h21, 32'h05);
      rd(32'h21, 32'h00);
      drain();

      // Rising-edge events and read-to-clear
      pins = 8'h07; idle(30);
      rd(32'h20, 32'h07);
      rd(32'h21, 32'h02);
      rd(32'h21, 32'h00);
      pins = 8'h05; idle(30);
      pins = 8'h07; idle(30);
      rd(32'h21, 32'h02);
      drain();

      // Write-1-to-clear
      pins = 8'h01; idle(30);
      rd(32'h21, 32'h00);
      pins = 8'h07; idle(30);
      wr(32'h21, 32'h04);
      rd(32'h21, 32'h02);
      rd(32'h21, 32'h00);
      drain();

      // Clear on the exact edge bit 2 is set: set must win
      pins = 8'h03; idle(30);
      pins = 8'h07;
      ep = edge_cnt + 1;
      t1 = ((ep + 2 + 3) / 4) * 4;
      r  = t1 + 12;
      while (edge_cnt < r - 2) @(negedge clk);
      acc(1'b1, 32'h21, 32'h04, 32'd0);
      idle(1);
      drain();
      rd(32'h21, 32'h04);
      rd(32'h21, 32'h00);
      drain();

      // Address decode
      miss(1'b0, 32'h22, 32'h0);
      miss(1'b0, 32'h1F, 32'h0);
      miss(1'b1, 32'h22, 32'hFF);
      miss(1'b1, 32'h1F, 32'hFF);
      wr(32'h20, 32'hFF);
      rd(32'h20, 32'h07);
      rd(32'h21, 32'h00);
      drain();

      // Back-to-back reads
      pins = 8'h03; idle(30);
      pins = 8'h07; idle(30);
      max_streak = 0;
      acc(1'b0, 32'h20, 32'h0, 32'h07);
      acc(1'b0, 32'h21, 32'h0, 32'h04);
      acc(1'b0, 32'h20, 32'h0, 32'h07);
      idle(1);
      drain();
      chk("b2b_ack_streak", max_streak, 32'd3);

      // Asynchronous reset in the middle of an access
      acc(1'b0, 32'h20, 32'h0, 32'h07);
      @(posedge clk);
      #1;
      chk("pre_reset_ack", {31'd0, ack}, 32'd1);
      chk("pre_reset_q", q, 32'h07);
      #1 reset = 1'b1;
      #1;
      chk("async_reset_q", q, 32'h0);
      chk("async_reset_ack", {31'd0, ack}, 32'd0);
      exp_q.delete();
      strobe = 1'b0;
      last_q = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rd(32'h20, 32'h0);
      rd(32'h21, 32'h0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
